// File: rtl/pc_unit_if.sv
// pc_unit_if: control-unit <-> program-counter bus.
// master = control unit (drives strobes/targets), slave = pc_unit.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              en_pc;
    logic              inc;
    logic              ld_abs;
    logic              ld_rel;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] adrs_in;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] adrs_out;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_err;

    modport master (
        output en_pc, inc, ld_abs, ld_rel, call, ret, adrs_in, offset,
        input  adrs_out, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  en_pc, inc, ld_abs, ld_rel, call, ret, adrs_in, offset,
        output adrs_out, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with increment, absolute load, PC-relative
// branch and an optional call/return address stack.
// Optional feature macro: PC_RET_STACK_EN (return-address stack, call/ret).
// All sums wrap modulo 2^ADDR_W; adrs_out comes straight from the PC register.
module pc_unit #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned INC_STEP     = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned STACK_DEPTH  = 4
) (
    input logic         clk,
    input logic         rst,
    pc_unit_if.slave    bus
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_inc_pc;
    logic [ADDR_W-1:0] w_rel_pc;

    assign w_inc_pc     = r_pc + ADDR_W'(INC_STEP);
    assign w_rel_pc     = r_pc + bus.offset;
    assign bus.adrs_out = r_pc;

`ifdef PC_RET_STACK_EN
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_err;
    logic              w_full;
    logic              w_empty;
    logic              w_do_ret;
    logic              w_do_call;
    logic              w_push;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    // ret outranks call, so a call only counts when ret is low
    assign w_do_ret  = bus.en_pc & bus.ret;
    assign w_do_call = bus.en_pc & ~bus.ret & bus.call;
    assign w_push    = w_do_call & ~w_full;
    assign w_wr_idx  = IDX_W'(r_sp);
    assign w_rd_idx  = IDX_W'(r_sp - SP_W'(1));

    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.stk_err   = r_err;

    // Return-address storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_stack[w_wr_idx] <= w_inc_pc;
        end
    end

    // PC, stack pointer and sticky error update in priority order
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc  <= ADDR_W'(RESET_VECTOR);
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (bus.en_pc) begin
            if (w_do_ret) begin
                if (w_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_sp <= r_sp - SP_W'(1);
                    r_pc <= r_stack[w_rd_idx];
                end
            end else if (w_do_call) begin
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_sp <= r_sp + SP_W'(1);
                    r_pc <= bus.adrs_in;
                end
            end else if (bus.ld_abs) begin
                r_pc <= bus.adrs_in;
            end else if (bus.ld_rel) begin
                r_pc <= w_rel_pc;
            end else if (bus.inc) begin
                r_pc <= w_inc_pc;
            end
        end
    end
`else
    logic w_unused_stk;

    assign w_unused_stk  = bus.call ^ bus.ret;
    assign bus.stk_full  = 1'b0;
    assign bus.stk_empty = 1'b1;
    assign bus.stk_err   = 1'b0;

    // PC update without call/ret: ld_abs > ld_rel > inc
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= ADDR_W'(RESET_VECTOR);
        end else if (bus.en_pc) begin
            if (bus.ld_abs) begin
                r_pc <= bus.adrs_in;
            end else if (bus.ld_rel) begin
                r_pc <= w_rel_pc;
            end else if (bus.inc) begin
                r_pc <= w_inc_pc;
            end
        end
    end
`endif
endmodule
